// File: rtl/mux4_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, select/channel widths, dwell counter width and
// a helper that picks the lowest non-skipped channel at or above a start
// index.
package mux4_scan_pkg;

  localparam int SEL_W  = 2;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    PRESENT
  } scan_state_t;

  typedef struct packed {
    logic             hit;
    logic [SEL_W-1:0] ch;
  } ch_pick_t;

  // Lowest channel index >= from whose skip bit is clear. 'from' is one bit
  // wider than a select so that "past the last channel" (4) is expressible.
  function automatic ch_pick_t next_ch(input logic [NUM_CH-1:0] skip,
                                       input logic [SEL_W:0]    from);
    ch_pick_t pick;
    pick.hit = 1'b0;
    pick.ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i >= int'(from) && !skip[i]) begin
        pick.hit = 1'b1;
        pick.ch  = SEL_W'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4_dwell_counter.sv
// Loadable down-counter that times the settle dwell of each channel.
// Latency: zero flag reflects the registered count; load takes effect next clock.
// Backpressure: none; counts down every clock and parks at zero.
//
// Ports:
//   CLK      - clock, rising edge
//   RESET    - asynchronous active-high reset, clears the count
//   load     - load load_val on the next edge (has priority over counting)
//   load_val - value to load
//   zero     - high while the count is zero
module mux4_dwell_counter
  import mux4_scan_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux4_scan_sequencer.sv
// Steps an external 4:1 mux through its channels and assembles a 4-bit word.
// Latency: VALID rises 4*(DWELL_CYCLES+1) clocks after the scan-start edge.
// Backpressure: VALID/DOUT held until a VALID&READY edge; READY ignored elsewhere.
//
// Ports:
//   CLK    - clock, rising edge
//   RESET  - asynchronous active-high reset; aborts any scan in progress
//   EN     - scan request, checked in IDLE and at word acceptance only
//   MASK   - per-channel skip mask (only honoured with MUX4_SCAN_MASK_EN)
//   Y      - output of the external mux
//   SEL    - select driving the external mux
//   DOUT   - assembled word, DOUT[n] = Y sampled with SEL==n
//   VALID  - DOUT holds a complete word
//   READY  - downstream accepts the word
//
// Optional feature: define MUX4_SCAN_MASK_EN to skip channels whose MASK bit
// is set. MASK is latched at scan start; skipped channels read as 0.
module mux4_scan_sequencer
  import mux4_scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [NUM_CH-1:0] MASK,
  input  logic              Y,
  output logic [SEL_W-1:0]  SEL,
  output logic [NUM_CH-1:0] DOUT,
  output logic              VALID,
  input  logic              READY
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DWELL_CYCLES - 1);

  scan_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;

  logic              cnt_load;
  logic              cnt_zero;
  logic              start_scan;

  // scan_mask: mask applied to a scan that starts this clock.
  // mask_q:    mask held for the scan in progress.
  logic [NUM_CH-1:0] scan_mask;
  logic [NUM_CH-1:0] mask_q;

  ch_pick_t          first_pick;
  ch_pick_t          next_pick;

`ifdef MUX4_SCAN_MASK_EN
  logic [NUM_CH-1:0] mask_d;

  assign scan_mask = MASK;

  always_comb begin
    mask_d = mask_q;
    if (start_scan) begin
      mask_d = MASK;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`else
  logic unused_mask;

  assign scan_mask   = '0;
  assign mask_q      = '0;
  assign unused_mask = ^MASK;
`endif

  assign first_pick = next_ch(scan_mask, '0);
  assign next_pick  = next_ch(mask_q, {1'b0, sel_q} + 3'd1);

  mux4_dwell_counter u_dwell (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    dout_d     = dout_q;
    valid_d    = valid_q;
    cnt_load   = 1'b0;
    start_scan = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d   = '0;
        valid_d = 1'b0;
        if (EN) begin
          start_scan = 1'b1;
        end
      end

      SETTLE: begin
        if (cnt_zero) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        // A masked channel only reaches CAPTURE when every channel is
        // masked; it then acts as a one-clock pass that records a 0.
        shadow_d[sel_q] = Y & ~mask_q[sel_q];
        if (next_pick.hit) begin
          sel_d    = next_pick.ch;
          cnt_load = 1'b1;
          state_d  = SETTLE;
        end else begin
          // Last channel: the word includes the bit captured this clock.
          dout_d  = shadow_d;
          valid_d = 1'b1;
          sel_d   = '0;
          state_d = PRESENT;
        end
      end

      PRESENT: begin
        if (READY) begin
          valid_d = 1'b0;
          if (EN) begin
            start_scan = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Common scan start, from IDLE or back-to-back from PRESENT.
    if (start_scan) begin
      shadow_d = '0;
      if (first_pick.hit) begin
        sel_d    = first_pick.ch;
        cnt_load = 1'b1;
        state_d  = SETTLE;
      end else begin
        sel_d   = '0;
        state_d = CAPTURE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  assign SEL   = sel_q;
  assign DOUT  = dout_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Bench for mux4_scan_sequencer with an external 4:1 mux model.
// Expected words go into a queue at stimulus time; a negedge monitor pops and
// compares each accepted word and checks back-to-back spacing.
module tb_mux4_scan_sequencer;

  localparam int D   = 4;
  localparam int LAT = 4 * (D + 1);

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] mask;
  logic       y;
  logic [1:0] sel;
  logic [3:0] dout;
  logic       valid;
  logic       ready;

  // ch[n] is the mux input selected by SEL==n ({a,b,c,d} = ch[0..3]).
  logic [3:0] ch;

  int         cyc;
  int         pass_cnt;
  int         chk_cnt;
  logic [3:0] exp_q[$];

  logic       prev_valid;
  logic       b2b_pending;
  int         acc_cyc;

  assign y = ch[sel];

  mux4_scan_sequencer #(.DWELL_CYCLES(D)) dut (
    .CLK   (clk),
    .RESET (rst),
    .EN    (en),
    .MASK  (mask),
    .Y     (y),
    .SEL   (sel),
    .DOUT  (dout),
    .VALID (valid),
    .READY (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      pass_cnt++;
    end
  endtask

  // Blocks until cyc reaches c, sampling at negedge.
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Waits up to maxc negedges for VALID; returns the cycle or -1.
  task automatic wait_valid(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (valid) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Issues a one-clock EN pulse; returns the cycle number of the sampling edge.
  task automatic pulse_en(output int s);
    en = 1'b1;
    s  = cyc + 1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid  = 1'b0;
      b2b_pending = 1'b0;
    end else begin
      if (valid && !prev_valid && b2b_pending) begin
        chk("b2b_spacing", cyc - acc_cyc, LAT + 1);
        b2b_pending = 1'b0;
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_word_expected", exp_q.size(), 1);
        end else begin
          chk("dout_word", int'(dout), int'(exp_q.pop_front()));
        end
        if (en) begin
          b2b_pending = 1'b1;
          acc_cyc     = cyc;
        end
      end
      prev_valid = valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int at;

    pass_cnt = 0;
    chk_cnt  = 0;
    rst      = 1'b1;
    en       = 1'b0;
    mask     = 4'b0000;
    ready    = 1'b0;
    ch       = 4'b0000;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", int'(sel), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_dout", int'(dout), 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single scan, {a,b,c,d} = 1,0,1,1 -> DOUT = 4'b1101.
    ch    = 4'b1101;
    ready = 1'b1;
    exp_q.push_back(4'b1101);
    pulse_en(s);
    wait_cyc(s + 2);  chk("t1_sel_ch0", int'(sel), 0);
    wait_cyc(s + 7);  chk("t1_sel_ch1", int'(sel), 1);
    wait_cyc(s + 12); chk("t1_sel_ch2", int'(sel), 2);
    wait_cyc(s + 17); chk("t1_sel_ch3", int'(sel), 3);
    wait_cyc(s + 19); chk("t1_valid_early", int'(valid), 0);
    wait_cyc(s + 20); chk("t1_valid_at_lat", int'(valid), 1);
    wait_cyc(s + 21); chk("t1_valid_cleared", int'(valid), 0);
    chk("t1_sel_home", int'(sel), 0);
    wait_cyc(s + 25); chk("t1_idle_no_valid", int'(valid), 0);
    chk("t1_dout_kept", int'(dout), 4'b1101);

    // Backpressure: READY low for 7 clocks after VALID.
    @(posedge clk);
    #1;
    ch    = 4'b0110;
    ready = 1'b0;
    exp_q.push_back(4'b0110);
    pulse_en(s);
    wait_valid(LAT + 10, at);
    chk("t2_latency", at - s, LAT);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      chk("t2_hold_valid", int'(valid), 1);
      chk("t2_hold_dout", int'(dout), 4'b0110);
    end
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t2_accepted_first_ready", int'(valid), 0);

    // Back-to-back scanning with EN held; EN drops during the third scan.
    @(posedge clk);
    #1;
    ch = 4'b0011;
    exp_q.push_back(4'b0011);
    en = 1'b1;
    s  = cyc + 1;
    wait_valid(LAT + 10, at);
    chk("t3_latency_first", at - s, LAT);
    @(posedge clk);
    #1;
    ch = 4'b1010;
    exp_q.push_back(4'b1010);
    wait_valid(LAT + 10, at);
    chk("t3_second_word", int'(valid), 1);
    @(posedge clk);
    #1;
    ch = 4'b0101;
    exp_q.push_back(4'b0101);
    en = 1'b0;
    wait_valid(LAT + 10, at);
    chk("t3_third_word_completes", int'(valid), 1);
    repeat (3) @(negedge clk);
    chk("t3_idle_valid", int'(valid), 0);
    chk("t3_idle_sel", int'(sel), 0);

    // Reset pulse while SEL==2, then a clean scan.
    @(posedge clk);
    #1;
    ch = 4'b1111;
    pulse_en(s);
    for (int i = 0; i < 3 * LAT; i++) begin
      @(negedge clk);
      if (sel == 2'd2) break;
    end
    chk("t4_reached_sel2", int'(sel), 2);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_sel", int'(sel), 0);
    chk("t4_rst_valid", int'(valid), 0);
    chk("t4_rst_dout", int'(dout), 0);
    @(posedge clk);
    #1;
    chk("t4_rst_hold_sel", int'(sel), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    ch = 4'b1001;
    exp_q.push_back(4'b1001);
    pulse_en(s);
    wait_valid(LAT + 10, at);
    chk("t4_latency_after_rst", at - s, LAT);
    repeat (2) @(negedge clk);

`ifdef MUX4_SCAN_MASK_EN
    // Mask 0101: only channels 1 and 3, half latency; MASK changed mid-scan.
    @(posedge clk);
    #1;
    ch   = 4'b1111;
    mask = 4'b0101;
    exp_q.push_back(4'b1010);
    en   = 1'b1;
    s    = cyc + 1;
    @(posedge clk);
    #1;
    en   = 1'b0;
    mask = 4'b0000;
    wait_cyc(s + 1); chk("m1_sel_ch1", int'(sel), 1);
    wait_cyc(s + 6); chk("m1_sel_ch3", int'(sel), 3);
    wait_valid(LAT, at);
    chk("m1_latency", at - s, 2 * (D + 1));
    repeat (2) @(negedge clk);

    // Mask 1111: word on the clock after scan start, all zero.
    @(posedge clk);
    #1;
    mask = 4'b1111;
    exp_q.push_back(4'b0000);
    pulse_en(s);
    mask = 4'b0000;
    wait_valid(10, at);
    chk("m2_latency", at - s, 1);
    repeat (2) @(negedge clk);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mux4_scan_sequencer.md
MUX4_SCAN_SEQUENCER -- requirements
Module: mux4_scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 4, meaning the number of settle clocks that SEL is held before Y is sampled; legal range 1..255.
REQ-002 SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 SHALL have port EN, input, 1 bit, the scan request.
REQ-005 SHALL have port MASK, input, 4 bits, the per-channel skip mask; it is honoured only when MUX4_SCAN_MASK_EN is defined.
REQ-006 SHALL have port Y, input, 1 bit, the output of the external 4:1 mux.
REQ-007 SHALL have port SEL, output, 2 bits, the select that drives the external 4:1 mux.
REQ-008 SHALL have port DOUT, output, 4 bits, the assembled word; DOUT[n] is Y sampled while SEL==n.
REQ-009 SHALL have port VALID, output, 1 bit, which is high when DOUT holds a complete word.
REQ-010 SHALL have port READY, input, 1 bit, which is the downstream acceptance of the word.

Function
REQ-011 SHALL implement the FSM states IDLE, SETTLE, CAPTURE and PRESENT.
REQ-012 In IDLE, SHALL hold SEL=0 and VALID=0; when EN=1 at an edge, SHALL go to SETTLE with SEL=0 and load the dwell counter with DWELL_CYCLES-1.
REQ-013 In SETTLE, SHALL decrement the counter each clock, so that SETTLE lasts exactly DWELL_CYCLES clocks, and SHALL go to CAPTURE when the count is 0.
REQ-014 In CAPTURE, which lasts 1 clock, SHALL write Y into shadow bit SEL.
- If SEL==3, SHALL go to PRESENT.
- Otherwise, SHALL increment SEL and re-enter SETTLE with the counter reloaded.
REQ-015 On entry to PRESENT, SHALL copy the shadow register to DOUT, set VALID=1 and return SEL to 0.
REQ-016 SHALL hold VALID and DOUT stable until a clock edge with VALID=1 and READY=1.
REQ-017 On acceptance in PRESENT:
- If EN=1, SHALL clear VALID and go to SETTLE (SEL=0), which is back-to-back scanning.
- Otherwise, SHALL clear VALID and go to IDLE.
REQ-018 SHALL assert VALID 4*(DWELL_CYCLES+1) clocks after the edge that samples EN=1 in IDLE; this is 20 clocks at the default.
REQ-019 SHALL complete any scan already started if EN falls mid-scan, and SHALL re-check EN only in IDLE and at acceptance.
REQ-020 SHALL ignore READY outside PRESENT.
REQ-021 SHALL ignore changes to Y except during CAPTURE.
REQ-022 SHALL keep DOUT at its last presented value outside PRESENT.

Reset
REQ-023 While RESET=1, SHALL hold state=IDLE, SEL=0, DOUT=0, VALID=0, shadow=0 and counter=0, independent of CLK.
REQ-024 If RESET asserts mid-scan or during PRESENT, SHALL abort the scan and discard the partial word; the first scan after release starts from SEL=0.

Configuration
REQ-025 With MUX4_SCAN_MASK_EN defined, SHALL skip any channel n with MASK[n]=1: no SETTLE or CAPTURE for that channel, and shadow bit n is forced to 0.
REQ-026 With MUX4_SCAN_MASK_EN defined, SHALL sample MASK once, at scan start, and hold it for the whole scan.
REQ-027 With MUX4_SCAN_MASK_EN defined and MASK=4'b1111, SHALL go to PRESENT on the clock after the scan starts, with DOUT=0.
REQ-028 Without MUX4_SCAN_MASK_EN, SHALL ignore MASK, scan all 4 channels, and keep the REQ-018 latency.

Structure
REQ-029 SHALL place the state enum type, SEL_W=2 and NUM_CH=4 in a shared package named mux4_scan_pkg.
REQ-030 SHALL implement the loadable down-counter as sub-module mux4_dwell_counter, with ports CLK, RESET, load, load value and zero flag.

Verification
REQ-031 With the bench connecting an external 4:1 mux with inputs {a,b,c,d}=4'b1011, DWELL_CYCLES=4, READY=1 and a single EN pulse, SHALL show SEL stepping 0,1,2,3, VALID high 20 clocks after EN, DOUT=4'b1101, then a return to IDLE.
REQ-032 With READY=0 for 7 clocks after VALID rises, SHALL hold VALID=1 and DOUT unchanged; the word SHALL be accepted on the first READY=1 edge.
REQ-033 With EN held high and the mux inputs changed between words, SHALL produce consecutive words with no idle clock between acceptance and the next SETTLE.
REQ-034 With RESET pulsed while SEL==2, SHALL take SEL, VALID and DOUT to 0 immediately; the next scan SHALL produce the correct full word.
REQ-035 With MUX4_SCAN_MASK_EN defined and MASK=4'b0101, SHALL visit SEL 1 and 3 only, assert VALID after 2*(DWELL_CYCLES+1) clocks, and give DOUT[0]=DOUT[2]=0.
REQ-036 With MUX4_SCAN_MASK_EN defined and MASK=4'b1111, SHALL assert VALID on the second clock after EN with DOUT=4'b0000.
